// File: rtl/ir_cmd_decoder.sv
// NEC IR frame validator and key decoder: maps keys to state_control, runs a toggle key
// with held-key suppression, counts rejected frames. Optional macro: IR_AUTO_REPEAT_EN.
module ir_cmd_decoder #(
    parameter int          STATE_W       = 3,
    parameter int          NUM_STATES    = 5,
    parameter logic [7:0]  KEY_BASE      = 8'h01,
    parameter logic [7:0]  TOGGLE_KEY    = 8'h12,
    parameter logic [7:0]  DEV_ADDR      = 8'h00,
    parameter int          HOLD_CYCLES   = 6_000_000,
    parameter int          REPEAT_PERIOD = 12_500_000,
    parameter int          ERR_W         = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               data_ready,
    input  logic [31:0]        ir_data,
    output logic [STATE_W-1:0] state_control,
    output logic               toggle,
    output logic               cmd_valid,
    output logic [7:0]         cmd_code,
    output logic               cmd_repeat,
    output logic [ERR_W-1:0]   err_cnt
);

    localparam int                HOLD_W      = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [8:0]        KEY_END     = 9'(KEY_BASE) + 9'(NUM_STATES);

    if (NUM_STATES > 2**STATE_W || HOLD_CYCLES < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("ir_cmd_decoder: illegal parameter combination");
    end

    logic [31:0]       frame_q;
    logic              v1;
    logic [HOLD_W-1:0] hold_cnt;
    logic [7:0]        last_cmd;

    logic [7:0] addr, naddr, cmd, ncmd;
    logic       frame_ok, accept, reject, is_repeat;

    assign addr  = frame_q[7:0];
    assign naddr = frame_q[15:8];
    assign cmd   = frame_q[23:16];
    assign ncmd  = frame_q[31:24];

    assign frame_ok  = (addr == DEV_ADDR) && ((addr ^ naddr) == 8'hFF) && ((cmd ^ ncmd) == 8'hFF);
    assign accept    = v1 && frame_ok;
    assign reject    = v1 && !frame_ok;
    assign is_repeat = (cmd == last_cmd) && (hold_cnt != '0);

    function automatic logic in_key_range(input logic [7:0] c);
        return (c >= KEY_BASE) && ({1'b0, c} < KEY_END);
    endfunction

    function automatic logic [STATE_W-1:0] key_state(input logic [7:0] c);
        logic [7:0] off;
        off = c - KEY_BASE;
        return STATE_W'(off);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
            v1      <= 1'b0;
        end else begin
            v1 <= data_ready;
            if (data_ready) frame_q <= ir_data;
        end
    end

`ifdef IR_AUTO_REPEAT_EN
    // state | meaning
    // IDLE  | no key held, no synthetic repeats
    // HELD  | key recently accepted; period counter issues repeats until hold_cnt runs out
    localparam int               PER_W      = $clog2(REPEAT_PERIOD + 1);
    localparam logic [PER_W-1:0] PER_RELOAD = PER_W'(REPEAT_PERIOD - 1);

    typedef enum logic {IDLE, HELD} ar_state_t;
    ar_state_t        ar_state, ar_state_nxt;
    logic [PER_W-1:0] per_cnt;
    logic             synth;

    always_ff @(posedge clk) begin
        if (rst) ar_state <= IDLE;
        else     ar_state <= ar_state_nxt;
    end

    always_comb begin
        ar_state_nxt = ar_state;
        synth        = 1'b0;
        case (ar_state)
            IDLE: if (accept) ar_state_nxt = HELD;
            HELD: begin
                if (accept)                ar_state_nxt = HELD;
                else if (hold_cnt == '0)   ar_state_nxt = IDLE;
                else if (per_cnt == '0)    synth = 1'b1;
            end
            default: ar_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)                                   per_cnt <= '0;
        else if (accept || synth)                  per_cnt <= PER_RELOAD;
        else if (ar_state == HELD && per_cnt != '0) per_cnt <= per_cnt - 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_control <= '0;
            toggle        <= 1'b0;
            cmd_valid     <= 1'b0;
            cmd_code      <= 8'h00;
            cmd_repeat    <= 1'b0;
            err_cnt       <= '0;
            hold_cnt      <= '0;
            last_cmd      <= 8'h00;
        end else begin
            cmd_valid <= 1'b0;
            if (accept) begin
                cmd_valid  <= 1'b1;
                cmd_code   <= cmd;
                cmd_repeat <= is_repeat;
                last_cmd   <= cmd;
                hold_cnt   <= HOLD_RELOAD;
                if (in_key_range(cmd)) state_control <= key_state(cmd);
                if (cmd == TOGGLE_KEY && !is_repeat) toggle <= ~toggle;
            end else begin
                if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
`ifdef IR_AUTO_REPEAT_EN
                // Synthetic repeats replay the held key but never flip toggle.
                if (synth) begin
                    cmd_valid  <= 1'b1;
                    cmd_code   <= last_cmd;
                    cmd_repeat <= 1'b1;
                    if (in_key_range(last_cmd)) state_control <= key_state(last_cmd);
                end
`endif
            end
            if (reject && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule
